// File: rtl/core_mem_arb.sv
// Round-robin / fixed-priority arbiter sharing one 36-bit Avalon master among four requesters.
// Define CORE_MEM_ARB_RR_EN for round-robin grants; otherwise port 0 has highest fixed priority.
module core_mem_arb #(
    parameter logic [3:0] PORT_EN = 4'b1111
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [17:0] s0_address,
    input  logic        s0_read,
    input  logic        s0_write,
    input  logic [35:0] s0_writedata,
    output logic [35:0] s0_readdata,
    output logic        s0_waitrequest,
    input  logic [17:0] s1_address,
    input  logic        s1_read,
    input  logic        s1_write,
    input  logic [35:0] s1_writedata,
    output logic [35:0] s1_readdata,
    output logic        s1_waitrequest,
    input  logic [17:0] s2_address,
    input  logic        s2_read,
    input  logic        s2_write,
    input  logic [35:0] s2_writedata,
    output logic [35:0] s2_readdata,
    output logic        s2_waitrequest,
    input  logic [17:0] s3_address,
    input  logic        s3_read,
    input  logic        s3_write,
    input  logic [35:0] s3_writedata,
    output logic [35:0] s3_readdata,
    output logic        s3_waitrequest,
    output logic [17:0] m_address,
    output logic        m_read,
    output logic        m_write,
    output logic [35:0] m_writedata,
    input  logic [35:0] m_readdata,
    input  logic        m_waitrequest
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} state_t;

    state_t      state_reg, state_next;
    logic [17:0] addr_arr [4];
    logic [35:0] wdata_arr [4];
    logic [3:0]  rd_vec, wr_vec, req_vec;
    logic        win_valid;
    logic [1:0]  win_idx;
    logic [17:0] cur_addr_reg;
    logic [35:0] cur_wdata_reg;
    logic        cur_write_reg;
    logic [1:0]  grant_reg;
    logic        m_read_reg, m_write_reg;
    logic [35:0] rdata_reg;
    logic [3:0]  wait_reg;
`ifdef CORE_MEM_ARB_RR_EN
    logic [1:0]  last_reg;
    logic [1:0]  cand;
`endif

    assign addr_arr[0]  = s0_address;
    assign addr_arr[1]  = s1_address;
    assign addr_arr[2]  = s2_address;
    assign addr_arr[3]  = s3_address;
    assign wdata_arr[0] = s0_writedata;
    assign wdata_arr[1] = s1_writedata;
    assign wdata_arr[2] = s2_writedata;
    assign wdata_arr[3] = s3_writedata;
    assign rd_vec       = {s3_read, s2_read, s1_read, s0_read};
    assign wr_vec       = {s3_write, s2_write, s1_write, s0_write};
    assign req_vec      = PORT_EN & (rd_vec | wr_vec);

    // Later (higher-priority) candidates overwrite earlier ones in the loop.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = 2'd0;
`ifdef CORE_MEM_ARB_RR_EN
        cand      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            cand = last_reg + 2'(k);
            if (req_vec[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
`else
        for (int k = 3; k >= 0; k--) begin
            if (req_vec[k]) begin
                win_valid = 1'b1;
                win_idx   = 2'(k);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (win_valid) state_next = ST_ISSUE;
            ST_ISSUE: if (!m_waitrequest) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_addr_reg  <= '0;
            cur_wdata_reg <= '0;
            cur_write_reg <= 1'b0;
            grant_reg     <= 2'd0;
            m_read_reg    <= 1'b0;
            m_write_reg   <= 1'b0;
            rdata_reg     <= '0;
            wait_reg      <= 4'hF;
`ifdef CORE_MEM_ARB_RR_EN
            last_reg      <= 2'd3;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        cur_addr_reg  <= addr_arr[win_idx];
                        cur_wdata_reg <= wdata_arr[win_idx];
                        // Write takes precedence when both strobes are raised.
                        cur_write_reg <= wr_vec[win_idx];
                        m_write_reg   <= wr_vec[win_idx];
                        m_read_reg    <= ~wr_vec[win_idx];
                        grant_reg     <= win_idx;
`ifdef CORE_MEM_ARB_RR_EN
                        last_reg      <= win_idx;
`endif
                    end
                end
                ST_ISSUE: begin
                    if (!m_waitrequest) begin
                        m_read_reg  <= 1'b0;
                        m_write_reg <= 1'b0;
                        if (!cur_write_reg) begin
                            rdata_reg <= m_readdata;
                        end
                        wait_reg <= ~(4'b0001 << grant_reg);
                    end
                end
                default: begin
                    wait_reg <= 4'hF;
                end
            endcase
        end
    end

    assign m_address      = cur_addr_reg;
    assign m_writedata    = cur_wdata_reg;
    assign m_read         = m_read_reg;
    assign m_write        = m_write_reg;
    assign s0_readdata    = rdata_reg;
    assign s1_readdata    = rdata_reg;
    assign s2_readdata    = rdata_reg;
    assign s3_readdata    = rdata_reg;
    assign s0_waitrequest = wait_reg[0];
    assign s1_waitrequest = wait_reg[1];
    assign s2_waitrequest = wait_reg[2];
    assign s3_waitrequest = wait_reg[3];

endmodule

// File: tb/tb_core_mem_arb.sv
// Scoreboard bench for core_mem_arb: expected completions are queued by the stimulus
// and checked by a separate monitor process; a second instance covers the port mask.
module tb_core_mem_arb;

    typedef struct {
        int          port;
        logic [35:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [17:0] s_addr [4];
    logic        s_rd [4];
    logic        s_wr [4];
    logic [35:0] s_wd [4];
    logic [35:0] s_rdd [4];
    logic        s_wait [4];
    logic [17:0] m_address;
    logic        m_read, m_write;
    logic [35:0] m_writedata;
    logic [35:0] m_readdata;
    logic        m_waitrequest;
    logic [35:0] ram_rdata = '0;
    int          stall_req = 0;
    int          stall_cnt = 0;

    logic        ms_rd [4];
    logic [35:0] ms_rdd [4];
    logic        ms_wait [4];
    logic [17:0] mm_address;
    logic        mm_read, mm_write;
    logic [35:0] mm_writedata;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    // Downstream RAM: stalls each transfer for stall_req cycles.
    assign m_readdata    = ram_rdata;
    assign m_waitrequest = (stall_cnt < stall_req);
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_cnt <= 0;
        else if (m_read || m_write) stall_cnt <= m_waitrequest ? stall_cnt + 1 : 0;
    end

    core_mem_arb dut (
        .clk(clk), .reset_n(reset_n),
        .s0_address(s_addr[0]), .s0_read(s_rd[0]), .s0_write(s_wr[0]), .s0_writedata(s_wd[0]),
        .s0_readdata(s_rdd[0]), .s0_waitrequest(s_wait[0]),
        .s1_address(s_addr[1]), .s1_read(s_rd[1]), .s1_write(s_wr[1]), .s1_writedata(s_wd[1]),
        .s1_readdata(s_rdd[1]), .s1_waitrequest(s_wait[1]),
        .s2_address(s_addr[2]), .s2_read(s_rd[2]), .s2_write(s_wr[2]), .s2_writedata(s_wd[2]),
        .s2_readdata(s_rdd[2]), .s2_waitrequest(s_wait[2]),
        .s3_address(s_addr[3]), .s3_read(s_rd[3]), .s3_write(s_wr[3]), .s3_writedata(s_wd[3]),
        .s3_readdata(s_rdd[3]), .s3_waitrequest(s_wait[3]),
        .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
        .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
    );

    core_mem_arb #(.PORT_EN(4'b1011)) u_msk (
        .clk(clk), .reset_n(reset_n),
        .s0_address(18'o0), .s0_read(ms_rd[0]), .s0_write(1'b0), .s0_writedata(36'o0),
        .s0_readdata(ms_rdd[0]), .s0_waitrequest(ms_wait[0]),
        .s1_address(18'o1), .s1_read(ms_rd[1]), .s1_write(1'b0), .s1_writedata(36'o0),
        .s1_readdata(ms_rdd[1]), .s1_waitrequest(ms_wait[1]),
        .s2_address(18'o2), .s2_read(ms_rd[2]), .s2_write(1'b0), .s2_writedata(36'o0),
        .s2_readdata(ms_rdd[2]), .s2_waitrequest(ms_wait[2]),
        .s3_address(18'o3), .s3_read(ms_rd[3]), .s3_write(1'b0), .s3_writedata(36'o0),
        .s3_readdata(ms_rdd[3]), .s3_waitrequest(ms_wait[3]),
        .m_address(mm_address), .m_read(mm_read), .m_write(mm_write), .m_writedata(mm_writedata),
        .m_readdata(36'o555555555555), .m_waitrequest(1'b0)
    );

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %o, expected %o", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next completion on the main instance; returns port and cycles waited.
    task automatic wait_done(input string name, output int port, output int cyc);
        port = -1;
        cyc  = 0;
        for (int c = 1; c <= 50; c++) begin
            tick();
            for (int i = 0; i < 4; i++) if (s_wait[i] === 1'b0) port = i;
            if (port >= 0) begin
                cyc = c;
                break;
            end
        end
        if (port < 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no completion within 50 cycles", name);
        end
    endtask

    task automatic monitor_loop();
        exp_t e;
        int   zeros;
        int   p;
        forever begin
            @(negedge clk);
            zeros = 0;
            p = 0;
            for (int i = 0; i < 4; i++) if (s_wait[i] === 1'b0) begin zeros++; p = i; end
            if (zeros > 0) begin
                check("one_hot_completion", 36'(zeros), 36'd1);
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 36'(p), 36'h0_ffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    $display("completion: port %0d readdata %o (expect port %0d data %o)",
                             p, s_rdd[p], e.port, e.rdata);
                    check("grant_port", 36'(p), 36'(e.port));
                    check("readdata", s_rdd[p], e.rdata);
                end
            end
        end
    endtask

    initial begin
        int p, cyc, hi, c2, c3, mr;
        fork
            monitor_loop();
        join_none

        for (int i = 0; i < 4; i++) begin
            s_addr[i] = '0; s_rd[i] = 1'b0; s_wr[i] = 1'b0; s_wd[i] = '0; ms_rd[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_read", 36'(m_read), 36'd0);
        check("rst_m_write", 36'(m_write), 36'd0);
        check("rst_m_address", 36'(m_address), 36'd0);
        check("rst_m_writedata", m_writedata, 36'd0);
        check("rst_readdata", s_rdd[0], 36'd0);
        check("rst_waits", 36'({s_wait[3], s_wait[2], s_wait[1], s_wait[0]}), 36'hF);
        reset_n = 1'b1;

        // Single read, zero waits.
        tick();
        s_addr[0] = 18'o000123; s_rd[0] = 1'b1; ram_rdata = 36'o123456701234;
        exp_q.push_back('{0, 36'o123456701234});
        tick();
        check("rd_m_read_n1", 36'(m_read), 36'd1);
        check("rd_m_address", 36'(m_address), 36'o000123);
        tick();
        check("rd_s0_wait_n2", 36'(s_wait[0]), 36'd0);
        s_rd[0] = 1'b0;
        tick();
        check("rd_m_read_n3", 36'(m_read), 36'd0);
        check("rd_s0_wait_n3", 36'(s_wait[0]), 36'd1);

        // Write with three stall cycles.
        s_addr[2] = 18'o200000; s_wd[2] = 36'o777000777000; s_wr[2] = 1'b1; stall_req = 3;
        exp_q.push_back('{2, 36'o123456701234});
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (m_write) begin
                hi++;
                check("wr_addr_stable", 36'(m_address), 36'o200000);
                check("wr_data_stable", m_writedata, 36'o777000777000);
            end else if (hi > 0) begin
                break;
            end
        end
        check("wr_strobe_cycles", 36'(hi), 36'd4);
        check("wr_s2_wait_done", 36'(s_wait[2]), 36'd0);
        s_wr[2] = 1'b0;
        stall_req = 0;
        tick();

        // Fairness with all four holding requests, starting from reset.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        ram_rdata = 36'o111111111111;
        for (int i = 0; i < 4; i++) begin s_addr[i] = 18'(i + 8); s_rd[i] = 1'b1; end
`ifdef CORE_MEM_ARB_RR_EN
        exp_q.push_back('{0, 36'o111111111111});
        exp_q.push_back('{1, 36'o111111111111});
        exp_q.push_back('{2, 36'o111111111111});
        exp_q.push_back('{3, 36'o111111111111});
        exp_q.push_back('{0, 36'o111111111111});
`else
        for (int k = 0; k < 5; k++) exp_q.push_back('{0, 36'o111111111111});
`endif
        for (int k = 0; k < 5; k++) begin
            wait_done("fair_done", p, cyc);
            if (k > 0) check("fair_spacing", 36'(cyc), 36'd3);
        end
        for (int i = 0; i < 4; i++) s_rd[i] = 1'b0;
        tick();

        // Reset during a stalled read; the abandoned transfer never completes.
        s_addr[1] = 18'o7; s_rd[1] = 1'b1; stall_req = 10;
        tick();
        check("rstmid_m_read_issue", 36'(m_read), 36'd1);
        tick();
        #2 reset_n = 1'b0;
        #1;
        check("rstmid_m_read_async", 36'(m_read), 36'd0);
        check("rstmid_waits", 36'({s_wait[3], s_wait[2], s_wait[1], s_wait[0]}), 36'hF);
        tick();
        reset_n = 1'b1;
        stall_req = 0;
        ram_rdata = 36'o222222222222;
        s_addr[0] = 18'o10; s_rd[0] = 1'b1;
        exp_q.push_back('{0, 36'o222222222222});
        exp_q.push_back('{1, 36'o222222222222});
        for (int k = 0; k < 2; k++) begin
            wait_done("rstmid_done", p, cyc);
            if (k == 0) check("rstmid_first_grant", 36'(p), 36'd0);
            if (p >= 0) s_rd[p] = 1'b0;
        end
        tick();

        // Masked instance: port 2 disabled, port 3 served once.
        ms_rd[2] = 1'b1; ms_rd[3] = 1'b1;
        c2 = 0; c3 = 0; mr = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (mm_read) mr++;
            if (ms_wait[2] === 1'b0) c2++;
            if (ms_wait[3] === 1'b0) begin
                c3++;
                check("msk_readdata", ms_rdd[3], 36'o555555555555);
                ms_rd[3] = 1'b0;
            end
        end
        check("msk_port3_completions", 36'(c3), 36'd1);
        check("msk_port2_completions", 36'(c2), 36'd0);
        check("msk_downstream_reads", 36'(mr), 36'd1);
        ms_rd[2] = 1'b0;

        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        check("scoreboard_drained", 36'(exp_q.size()), 36'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
